// File: rtl/cache_pkg.sv
// Shared encodings and line geometry for the I/D cache miss arbiter and the
// fill FSM that sits beside it.
package cache_pkg;

  localparam int ADDR_W           = 16;
  localparam int LINE_CHUNKS      = 8;
  localparam int BUSY_TIMEOUT     = 4;
  localparam int LINE_OFFSET_BITS = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT_BUSY,
    ST_FILL,
    ST_DONE
  } arb_state_t;

  typedef enum logic {
    OWNER_I = 1'b0,
    OWNER_D = 1'b1
  } owner_t;

  // Byte address -> address of the first byte of its cache line.
  function automatic logic [ADDR_W-1:0] line_base(input logic [ADDR_W-1:0] addr);
    logic [ADDR_W-1:0] mask;
    mask = '1;
    mask = mask << LINE_OFFSET_BITS;
    return addr & mask;
  endfunction

endpackage

// File: rtl/cache_miss_arbiter.sv
// Arbitrates I- and D-cache misses onto a single line-fill FSM, routes the fill
// strobes back to the owning cache and flags fill-protocol violations.
module cache_miss_arbiter
  import cache_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              icache_miss,
  input  logic [ADDR_W-1:0] icache_addr,
  input  logic              dcache_miss,
  input  logic [ADDR_W-1:0] dcache_addr,
  input  logic              fsm_busy,
  input  logic              fill_write_data,
  input  logic              fill_write_tag,
  input  logic [ADDR_W-1:0] fill_data,
  output logic              miss_detected,
  output logic [ADDR_W-1:0] miss_address,
  output logic              icache_write_data,
  output logic              icache_write_tag,
  output logic              dcache_write_data,
  output logic              dcache_write_tag,
  output logic [ADDR_W-1:0] cache_fill_data,
  output logic              icache_stall,
  output logic              dcache_stall,
  output logic              protocol_err
);

  localparam int WAIT_W = $clog2(BUSY_TIMEOUT);

  arb_state_t        state_reg, state_next;
  owner_t            owner_reg, owner_next;
  owner_t            last_grant_reg, last_grant_next;
  owner_t            grant;
  logic [ADDR_W-1:0] miss_address_reg, miss_address_next;
  logic [WAIT_W-1:0] wait_cnt_reg, wait_cnt_next;
  logic [3:0]        data_cnt_reg, data_cnt_next;
  logic [1:0]        tag_cnt_reg, tag_cnt_next;
  logic              err_reg, err_next;

  logic [1:0] miss_vec;
  logic [1:0] route_data;
  logic [1:0] route_tag;
  logic [1:0] stall_vec;
  logic       in_fill;

  assign miss_vec = {dcache_miss, icache_miss};
  // Reset gates every routed strobe so a fill interrupted by reset goes quiet at once.
  assign in_fill  = (state_reg == ST_FILL) && !rst;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_route
      localparam owner_t GI_OWNER = (gi == 1) ? OWNER_D : OWNER_I;
      assign route_data[gi] = in_fill && (owner_reg == GI_OWNER) && fill_write_data;
      assign route_tag[gi]  = in_fill && (owner_reg == GI_OWNER) && fill_write_tag;
      assign stall_vec[gi]  = miss_vec[gi] ||
                              (!rst && (owner_reg == GI_OWNER) && (state_reg != ST_IDLE));
    end
  endgenerate

  assign icache_write_data = route_data[OWNER_I];
  assign icache_write_tag  = route_tag[OWNER_I];
  assign dcache_write_data = route_data[OWNER_D];
  assign dcache_write_tag  = route_tag[OWNER_D];
  assign icache_stall      = stall_vec[OWNER_I];
  assign dcache_stall      = stall_vec[OWNER_D];
  assign miss_detected     = (state_reg == ST_ISSUE) && !rst;
  assign miss_address      = miss_address_reg;
  assign cache_fill_data   = fill_data;
  assign protocol_err      = err_reg;

  always_comb begin
    state_next        = state_reg;
    owner_next        = owner_reg;
    last_grant_next   = last_grant_reg;
    miss_address_next = miss_address_reg;
    wait_cnt_next     = wait_cnt_reg;
    data_cnt_next     = data_cnt_reg;
    tag_cnt_next      = tag_cnt_reg;
    err_next          = err_reg;
    grant             = OWNER_I;

    if ((fill_write_data || fill_write_tag) && (state_reg != ST_FILL)) begin
      err_next = 1'b1;
    end

    case (state_reg)
      ST_IDLE: begin
        if (icache_miss || dcache_miss) begin
          // On a tie the cache that lost last time wins, so neither side starves.
          if (icache_miss && dcache_miss) begin
            grant = (last_grant_reg == OWNER_I) ? OWNER_D : OWNER_I;
          end else begin
            grant = dcache_miss ? OWNER_D : OWNER_I;
          end
          owner_next        = grant;
          last_grant_next   = grant;
          miss_address_next = line_base((grant == OWNER_D) ? dcache_addr : icache_addr);
          wait_cnt_next     = '0;
          data_cnt_next     = '0;
          tag_cnt_next      = '0;
          state_next        = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        wait_cnt_next = '0;
        state_next    = ST_WAIT_BUSY;
      end
      ST_WAIT_BUSY: begin
        if (fsm_busy) begin
          state_next = ST_FILL;
        end else if (wait_cnt_reg == WAIT_W'(BUSY_TIMEOUT - 1)) begin
          err_next   = 1'b1;
          state_next = ST_DONE;
        end else begin
          wait_cnt_next = wait_cnt_reg + 1'b1;
        end
      end
      ST_FILL: begin
        data_cnt_next = data_cnt_reg + {3'b000, fill_write_data};
        tag_cnt_next  = tag_cnt_reg + {1'b0, fill_write_tag};
        if (!fsm_busy) begin
          state_next = ST_DONE;
          if ((data_cnt_next != 4'(LINE_CHUNKS)) || (tag_cnt_next != 2'd1)) begin
            err_next = 1'b1;
          end
        end
      end
      ST_DONE: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg        <= ST_IDLE;
      owner_reg        <= OWNER_I;
      last_grant_reg   <= OWNER_I;
      miss_address_reg <= '0;
      wait_cnt_reg     <= '0;
      data_cnt_reg     <= '0;
      tag_cnt_reg      <= '0;
      err_reg          <= 1'b0;
    end else begin
      state_reg        <= state_next;
      owner_reg        <= owner_next;
      last_grant_reg   <= last_grant_next;
      miss_address_reg <= miss_address_next;
      wait_cnt_reg     <= wait_cnt_next;
      data_cnt_reg     <= data_cnt_next;
      tag_cnt_reg      <= tag_cnt_next;
      err_reg          <= err_next;
    end
  end

endmodule

// File: tb/tb_cache_miss_arbiter.sv
// Directed scenarios for cache_miss_arbiter with a behavioural fill FSM and a
// queue of expected grant addresses checked on each miss_detected pulse.
module tb_cache_miss_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        icache_miss = 1'b0;
  logic [15:0] icache_addr = 16'h0;
  logic        dcache_miss = 1'b0;
  logic [15:0] dcache_addr = 16'h0;
  logic        fsm_busy = 1'b0;
  logic        fill_write_data = 1'b0;
  logic        fill_write_tag = 1'b0;
  logic [15:0] fill_data = 16'h0;
  logic        miss_detected;
  logic [15:0] miss_address;
  logic        icache_write_data, icache_write_tag;
  logic        dcache_write_data, dcache_write_tag;
  logic [15:0] cache_fill_data;
  logic        icache_stall, dcache_stall;
  logic        protocol_err;

  int checks = 0;
  int failures = 0;
  logic [15:0] exp_q[$];
  int n_md = 0, n_iwd = 0, n_iwt = 0, n_dwd = 0, n_dwt = 0;

  cache_miss_arbiter dut (
    .clk(clk), .rst(rst),
    .icache_miss(icache_miss), .icache_addr(icache_addr),
    .dcache_miss(dcache_miss), .dcache_addr(dcache_addr),
    .fsm_busy(fsm_busy), .fill_write_data(fill_write_data),
    .fill_write_tag(fill_write_tag), .fill_data(fill_data),
    .miss_detected(miss_detected), .miss_address(miss_address),
    .icache_write_data(icache_write_data), .icache_write_tag(icache_write_tag),
    .dcache_write_data(dcache_write_data), .dcache_write_tag(dcache_write_tag),
    .cache_fill_data(cache_fill_data),
    .icache_stall(icache_stall), .dcache_stall(dcache_stall),
    .protocol_err(protocol_err)
  );

  always #5 clk = ~clk;

  // Pulse/strobe counters, sampled on the inactive edge.
  always @(negedge clk) begin
    if (miss_detected)     n_md  <= n_md + 1;
    if (icache_write_data) n_iwd <= n_iwd + 1;
    if (icache_write_tag)  n_iwt <= n_iwt + 1;
    if (dcache_write_data) n_dwd <= n_dwd + 1;
    if (dcache_write_tag)  n_dwt <= n_dwt + 1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    icache_miss = 1'b0; dcache_miss = 1'b0;
    fsm_busy = 1'b0; fill_write_data = 1'b0; fill_write_tag = 1'b0;
    exp_q.delete();
    tick();
    rst = 1'b0;
  endtask

  // Waits (bounded) for a miss_detected pulse and checks it against the scoreboard.
  task automatic wait_md(output bit ok);
    logic [15:0] e;
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (miss_detected) begin
        ok = 1'b1;
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL grant_addr: unexpected miss_detected, miss_address=%h, none expected", miss_address);
        end else begin
          e = exp_q.pop_front();
          if (miss_address !== e) begin
            failures++;
            $display("FAIL grant_addr: miss_address=%h expected=%h", miss_address, e);
          end
        end
        return;
      end
    end
    checks++;
    failures++;
    $display("FAIL md_timeout: no miss_detected within 40 cycles, expected one");
  endtask

  // Behavioural fill FSM: busy, nd data writes, nt tag writes, then busy drops.
  task automatic do_fill(input int nd, input int nt, input bit drop_i, input bit drop_d);
    bit ok;
    wait_md(ok);
    if (!ok) return;
    tick();
    fsm_busy = 1'b1;
    for (int i = 0; i < nd; i++) begin
      tick();
      fill_write_data = 1'b1;
      fill_data = 16'hA000 + 16'(i);
    end
    for (int i = 0; i < nt; i++) begin
      tick();
      fill_write_data = 1'b0;
      fill_write_tag = 1'b1;
    end
    tick();
    fill_write_data = 1'b0;
    fill_write_tag = 1'b0;
    fsm_busy = 1'b0;
    if (drop_i) icache_miss = 1'b0;
    if (drop_d) dcache_miss = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    icache_miss = 1'b1; dcache_miss = 1'b0;
    fill_write_data = 1'b1; fill_write_tag = 1'b1;
    tick();
    @(negedge clk);
    checks++; if (miss_detected !== 1'b0) begin failures++; $display("FAIL rst_md: got=%b expected=0", miss_detected); end
    checks++; if ({icache_write_data, icache_write_tag, dcache_write_data, dcache_write_tag} !== 4'b0000) begin
      failures++; $display("FAIL rst_strobes: got=%b expected=0000",
        {icache_write_data, icache_write_tag, dcache_write_data, dcache_write_tag}); end
    checks++; if ({icache_stall, dcache_stall} !== 2'b10) begin failures++; $display("FAIL rst_stall: got=%b expected=10", {icache_stall, dcache_stall}); end
    checks++; if (miss_address !== 16'h0) begin failures++; $display("FAIL rst_addr: got=%h expected=0000", miss_address); end
    checks++; if (protocol_err !== 1'b0) begin failures++; $display("FAIL rst_err: got=%b expected=0", protocol_err); end
    icache_miss = 1'b0; fill_write_data = 1'b0; fill_write_tag = 1'b0;
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_single_d();
    int md0, iwd0, iwt0, dwd0, dwt0;
    apply_reset();
    md0 = n_md; iwd0 = n_iwd; iwt0 = n_iwt; dwd0 = n_dwd; dwt0 = n_dwt;
    dcache_addr = 16'h1234; dcache_miss = 1'b1; fill_data = 16'hBEEF;
    exp_q.push_back(16'h1230);
    @(negedge clk);
    checks++; if (cache_fill_data !== 16'hBEEF) begin failures++; $display("FAIL fill_passthru: got=%h expected=beef", cache_fill_data); end
    do_fill(8, 1, 1'b0, 1'b1);
    @(negedge clk);
    checks++; if (dcache_stall !== 1'b1) begin failures++; $display("FAIL d_stall_fill: got=%b expected=1", dcache_stall); end
    @(negedge clk);
    checks++; if (dcache_stall !== 1'b1) begin failures++; $display("FAIL d_stall_done: got=%b expected=1", dcache_stall); end
    @(negedge clk);
    checks++; if (dcache_stall !== 1'b0) begin failures++; $display("FAIL d_stall_idle: got=%b expected=0", dcache_stall); end
    tick();
    checks++; if (n_md - md0 != 1) begin failures++; $display("FAIL single_md_count: got=%0d expected=1", n_md - md0); end
    checks++; if (n_dwd - dwd0 != 8) begin failures++; $display("FAIL single_d_data: got=%0d expected=8", n_dwd - dwd0); end
    checks++; if (n_dwt - dwt0 != 1) begin failures++; $display("FAIL single_d_tag: got=%0d expected=1", n_dwt - dwt0); end
    checks++; if ((n_iwd - iwd0) + (n_iwt - iwt0) != 0) begin failures++;
      $display("FAIL single_i_strobes: got=%0d expected=0", (n_iwd - iwd0) + (n_iwt - iwt0)); end
    checks++; if (protocol_err !== 1'b0) begin failures++; $display("FAIL single_err: got=%b expected=0", protocol_err); end
  endtask

  task automatic test_simultaneous();
    int md0;
    apply_reset();
    md0 = n_md;
    icache_addr = 16'h5678; dcache_addr = 16'h9ABC;
    icache_miss = 1'b1; dcache_miss = 1'b1;
    exp_q.push_back(16'h9AB0);
    exp_q.push_back(16'h5670);
    do_fill(8, 1, 1'b0, 1'b1);
    do_fill(8, 1, 1'b1, 1'b0);
    repeat (4) tick();
    checks++; if (n_md - md0 != 2) begin failures++; $display("FAIL simul_md_count: got=%0d expected=2", n_md - md0); end
    checks++; if (protocol_err !== 1'b0) begin failures++; $display("FAIL simul_err: got=%b expected=0", protocol_err); end
  endtask

  task automatic test_back_to_back();
    int md0;
    apply_reset();
    md0 = n_md;
    icache_addr = 16'h4444; dcache_addr = 16'h2222;
    icache_miss = 1'b1; dcache_miss = 1'b1;
    exp_q.push_back(16'h2220);
    exp_q.push_back(16'h4440);
    exp_q.push_back(16'h3330);
    do_fill(8, 1, 1'b0, 1'b0);
    dcache_addr = 16'h3338;
    do_fill(8, 1, 1'b1, 1'b0);
    do_fill(8, 1, 1'b0, 1'b1);
    repeat (4) tick();
    checks++; if (n_md - md0 != 3) begin failures++; $display("FAIL b2b_md_count: got=%0d expected=3", n_md - md0); end
    checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL b2b_pending: got=%0d expected=0", exp_q.size()); end
  endtask

  task automatic test_busy_timeout();
    int md0;
    bit ok;
    apply_reset();
    md0 = n_md;
    dcache_addr = 16'h0ABC; dcache_miss = 1'b1;
    exp_q.push_back(16'h0AB0);
    wait_md(ok);
    dcache_miss = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      checks++; if (protocol_err !== 1'b0) begin failures++; $display("FAIL timeout_early: cycle=%0d got=%b expected=0", i, protocol_err); end
    end
    @(negedge clk);
    checks++; if (protocol_err !== 1'b1) begin failures++; $display("FAIL timeout_err: got=%b expected=1", protocol_err); end
    @(negedge clk);
    checks++; if (dcache_stall !== 1'b0) begin failures++; $display("FAIL timeout_idle: dcache_stall=%b expected=0", dcache_stall); end
    checks++; if (protocol_err !== 1'b1) begin failures++; $display("FAIL timeout_sticky: got=%b expected=1", protocol_err); end
    repeat (3) tick();
    checks++; if (n_md - md0 != 1) begin failures++; $display("FAIL timeout_md_count: got=%0d expected=1", n_md - md0); end
  endtask

  task automatic test_short_fill();
    apply_reset();
    dcache_addr = 16'h7777; dcache_miss = 1'b1;
    exp_q.push_back(16'h7770);
    do_fill(7, 1, 1'b0, 1'b1);
    @(negedge clk);
    checks++; if (protocol_err !== 1'b0) begin failures++; $display("FAIL short_before: got=%b expected=0", protocol_err); end
    @(negedge clk);
    checks++; if (protocol_err !== 1'b1) begin failures++; $display("FAIL short_err: got=%b expected=1", protocol_err); end
    apply_reset();
    @(negedge clk);
    checks++; if (protocol_err !== 1'b0) begin failures++; $display("FAIL stray_clear: got=%b expected=0", protocol_err); end
    tick();
    fill_write_data = 1'b1;
    @(negedge clk);
    checks++; if ({icache_write_data, dcache_write_data} !== 2'b00) begin failures++;
      $display("FAIL stray_route: got=%b expected=00", {icache_write_data, dcache_write_data}); end
    tick();
    fill_write_data = 1'b0;
    @(negedge clk);
    checks++; if (protocol_err !== 1'b1) begin failures++; $display("FAIL stray_err: got=%b expected=1", protocol_err); end
  endtask

  task automatic test_reset_mid_fill();
    int md0, iwd0;
    bit ok;
    apply_reset();
    md0 = n_md;
    icache_addr = 16'h5678; icache_miss = 1'b1;
    exp_q.push_back(16'h5670);
    wait_md(ok);
    tick(); fsm_busy = 1'b1;
    tick(); fill_write_data = 1'b1;
    tick();
    tick(); rst = 1'b1;
    @(negedge clk);
    checks++; if ({icache_write_data, dcache_write_data, icache_write_tag, dcache_write_tag} !== 4'b0000) begin failures++;
      $display("FAIL rstfill_route: got=%b expected=0000",
        {icache_write_data, dcache_write_data, icache_write_tag, dcache_write_tag}); end
    tick();
    rst = 1'b0; fsm_busy = 1'b0; fill_write_data = 1'b0;
    iwd0 = n_iwd;
    exp_q.push_back(16'h5670);
    do_fill(8, 1, 1'b1, 1'b0);
    repeat (4) tick();
    checks++; if (n_iwd - iwd0 != 8) begin failures++; $display("FAIL rstfill_data: got=%0d expected=8", n_iwd - iwd0); end
    checks++; if (n_md - md0 != 2) begin failures++; $display("FAIL rstfill_md_count: got=%0d expected=2", n_md - md0); end
    checks++; if (protocol_err !== 1'b0) begin failures++; $display("FAIL rstfill_err: got=%b expected=0", protocol_err); end
  endtask

  initial begin
    test_reset();
    test_single_d();
    test_simultaneous();
    test_back_to_back();
    test_busy_timeout();
    test_short_fill();
    test_reset_mid_fill();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
